// File: rtl/pipe_ctrl_seq.sv
// Central pipeline sequencer: merges hazard, memory-wait and mul/div
// stall sources into PC and per-stage register controls.
module pipe_ctrl_seq #(
  parameter int XLEN       = 32,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_use_stall,
  input  logic            branch_flush,
  input  logic [XLEN-1:0] branch_target,
  input  logic            mem_busy,
  input  logic            md_start,
  input  logic            md_done,
  output logic            pc_we,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            if_id_we,
  output logic            if_id_flush,
  output logic            id_ex_we,
  output logic            id_ex_bubble,
  output logic            ex_mem_we,
  output logic            ex_mem_bubble,
  output logic            mem_wb_we,
  output logic            md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MDW = $clog2(MD_TIMEOUT + 1);
  localparam logic [MDW-1:0] MD_LAST = MDW'(MD_TIMEOUT - 1);

  typedef enum logic {
    S_RUN,
    S_MD_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic              pend_v_q, pend_v_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic [MDW-1:0]    md_cnt_q, md_cnt_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic            pc_we_c;
  logic            redir_c;
  logic [XLEN-1:0] rpc_c;
  logic            if_id_we_c;
  logic            if_id_fl_c;
  logic            id_ex_we_c;
  logic            id_ex_bb_c;
  logic            ex_mem_we_c;
  logic            ex_mem_bb_c;
  logic            mem_wb_we_c;
  logic            md_hit;

  assign md_hit = (md_cnt_q >= MD_LAST);

  always_comb begin
    state_d     = state_q;
    pend_v_d    = pend_v_q;
    pend_pc_d   = pend_pc_q;
    md_cnt_d    = md_cnt_q;
    tmo_d       = tmo_q;
    pc_we_c     = 1'b1;
    redir_c     = 1'b0;
    rpc_c       = '0;
    if_id_we_c  = 1'b1;
    if_id_fl_c  = 1'b0;
    id_ex_we_c  = 1'b1;
    id_ex_bb_c  = 1'b0;
    ex_mem_we_c = 1'b1;
    ex_mem_bb_c = 1'b0;
    mem_wb_we_c = 1'b1;

    unique case (state_q)
      S_RUN: begin
        if (mem_busy) begin
          pc_we_c     = 1'b0;
          if_id_we_c  = 1'b0;
          id_ex_we_c  = 1'b0;
          ex_mem_we_c = 1'b0;
          mem_wb_we_c = 1'b0;
          if (branch_flush) begin
            pend_v_d  = 1'b1;
            pend_pc_d = branch_target;
          end
        end else if (branch_flush || pend_v_q) begin
          redir_c     = 1'b1;
          rpc_c       = branch_flush ? branch_target : pend_pc_q;
          if_id_fl_c  = 1'b1;
          id_ex_bb_c  = 1'b1;
          ex_mem_bb_c = 1'b1;
          pend_v_d    = 1'b0;
        end else if (md_start) begin
          pc_we_c     = 1'b0;
          if_id_we_c  = 1'b0;
          id_ex_we_c  = 1'b0;
          ex_mem_bb_c = 1'b1;
          md_cnt_d    = '0;
          state_d     = S_MD_WAIT;
        end else if (load_use_stall) begin
          pc_we_c    = 1'b0;
          if_id_we_c = 1'b0;
          id_ex_bb_c = 1'b1;
        end
      end
      S_MD_WAIT: begin
        pc_we_c     = 1'b0;
        if_id_we_c  = 1'b0;
        id_ex_we_c  = 1'b0;
        ex_mem_bb_c = 1'b1;
        if (md_cnt_q != '1) md_cnt_d = md_cnt_q + 1'b1;
        if (branch_flush) begin
          pend_v_d  = 1'b1;
          pend_pc_d = branch_target;
        end
        // A timeout during a memory freeze waits for the freeze to end.
        if (mem_busy) begin
          ex_mem_we_c = 1'b0;
          ex_mem_bb_c = 1'b0;
          mem_wb_we_c = 1'b0;
        end else if (md_done || md_hit) begin
          ex_mem_bb_c = 1'b0;
          id_ex_bb_c  = 1'b1;
          state_d     = S_RUN;
          if (!md_done) tmo_d = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase

    stall_d = stall_q;
    if (!pc_we_c && stall_q != '1) stall_d = stall_q + 1'b1;
    flush_d = flush_q;
    if (redir_c && flush_q != '1) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
      md_cnt_q  <= '0;
      tmo_q     <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
      md_cnt_q  <= md_cnt_d;
      tmo_q     <= tmo_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign pc_we         = rst_n & pc_we_c;
  assign pc_redirect   = rst_n & redir_c;
  assign redirect_pc   = rst_n ? rpc_c : '0;
  assign if_id_we      = rst_n & if_id_we_c;
  assign if_id_flush   = rst_n & if_id_fl_c;
  assign id_ex_we      = rst_n & id_ex_we_c;
  assign id_ex_bubble  = rst_n & id_ex_bb_c;
  assign ex_mem_we     = rst_n & ex_mem_we_c;
  assign ex_mem_bubble = rst_n & ex_mem_bb_c;
  assign mem_wb_we     = rst_n & mem_wb_we_c;
  assign md_timeout    = tmo_q;
  assign stall_cnt     = stall_q;
  assign flush_cnt     = flush_q;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Directed scoreboard bench for pipe_ctrl_seq.
// Expected controls are queued per step and checked on the falling edge.
module tb_pipe_ctrl_seq;

  typedef struct packed {
    logic pc_we;
    logic redir;
    logic if_id_we;
    logic if_id_fl;
    logic id_ex_we;
    logic id_ex_bb;
    logic ex_mem_we;
    logic ex_mem_bb;
    logic mem_wb_we;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [31:0] rpc;
    logic        tmo;
  } exp_t;

  localparam ctl_t IDLE  = 9'b1_0_1_0_1_0_1_0_1;
  localparam ctl_t FRZ   = 9'b0_0_0_0_0_0_0_0_0;
  localparam ctl_t REDIR = 9'b1_1_1_1_1_1_1_1_1;
  localparam ctl_t MDW   = 9'b0_0_0_0_0_0_1_1_1;
  localparam ctl_t MDREL = 9'b0_0_0_0_0_1_1_0_1;
  localparam ctl_t LU    = 9'b0_0_0_0_1_1_1_0_1;
  localparam ctl_t RST   = 9'b0_0_0_0_0_0_0_0_0;

  logic        clk;
  logic        rst_n;
  logic        load_use_stall;
  logic        branch_flush;
  logic [31:0] branch_target;
  logic        mem_busy;
  logic        md_start;
  logic        md_done;
  logic        pc_we;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        if_id_we;
  logic        if_id_flush;
  logic        id_ex_we;
  logic        id_ex_bubble;
  logic        ex_mem_we;
  logic        ex_mem_bubble;
  logic        mem_wb_we;
  logic        md_timeout;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  exp_t exp_q[$];
  int   checks;
  int   fails;
  int   exp_stall;
  int   exp_flush;

  pipe_ctrl_seq #(
    .XLEN(32),
    .MD_TIMEOUT(8),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load_use_stall(load_use_stall),
    .branch_flush(branch_flush),
    .branch_target(branch_target),
    .mem_busy(mem_busy),
    .md_start(md_start),
    .md_done(md_done),
    .pc_we(pc_we),
    .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc),
    .if_id_we(if_id_we),
    .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we),
    .id_ex_bubble(id_ex_bubble),
    .ex_mem_we(ex_mem_we),
    .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_we(mem_wb_we),
    .md_timeout(md_timeout),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag, input bit count);
    exp_t e;
    ctl_t got;
    e = exp_q.pop_front();
    got = {pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we,
           id_ex_bubble, ex_mem_we, ex_mem_bubble, mem_wb_we};
    checks++;
    assert (got === e.ctl) else begin
      fails++;
      $error("FAIL %s ctl got=%b exp=%b", tag, got, e.ctl);
    end
    checks++;
    assert (redirect_pc === e.rpc) else begin
      fails++;
      $error("FAIL %s rpc got=%h exp=%h", tag, redirect_pc, e.rpc);
    end
    checks++;
    assert (md_timeout === e.tmo) else begin
      fails++;
      $error("FAIL %s tmo got=%b exp=%b", tag, md_timeout, e.tmo);
    end
    checks++;
    assert (stall_cnt === 16'(exp_stall)) else begin
      fails++;
      $error("FAIL %s stall got=%0d exp=%0d", tag, stall_cnt, exp_stall);
    end
    checks++;
    assert (flush_cnt === 16'(exp_flush)) else begin
      fails++;
      $error("FAIL %s flush got=%0d exp=%0d", tag, flush_cnt, exp_flush);
    end
    if (count) begin
      if (!e.ctl.pc_we) exp_stall++;
      if (e.ctl.redir) exp_flush++;
    end
  endtask

  task automatic step(input string tag,
                      input logic lu, input logic bf,
                      input logic [31:0] bt,
                      input logic mb, input logic ms,
                      input logic md,
                      input ctl_t c, input logic [31:0] rpc,
                      input logic tmo);
    load_use_stall = lu;
    branch_flush   = bf;
    branch_target  = bt;
    mem_busy       = mb;
    md_start       = ms;
    md_done        = md;
    exp_q.push_back('{ctl: c, rpc: rpc, tmo: tmo});
    @(negedge clk);
    check_out(tag, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic tmo);
    step(tag, 0, 0, 32'h0, 0, 0, 0, IDLE, 32'h0, tmo);
  endtask

  task automatic check_reset(input string tag);
    load_use_stall = 1'b0;
    branch_flush   = 1'b0;
    branch_target  = 32'h0;
    mem_busy       = 1'b0;
    md_start       = 1'b0;
    md_done        = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    exp_q.push_back('{ctl: RST, rpc: 32'h0, tmo: 1'b0});
    @(negedge clk);
    check_out(tag, 1'b0);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    check_reset("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) idle("idle", 0);

    step("br40", 0, 1, 32'h40, 0, 0, 0, REDIR, 32'h40, 0);
    idle("post_br", 0);

    step("busy1", 0, 0, 32'h0, 1, 0, 0, FRZ, 32'h0, 0);
    step("busy2", 0, 1, 32'h80, 1, 0, 0, FRZ, 32'h0, 0);
    step("busy3", 0, 0, 32'h0, 1, 0, 0, FRZ, 32'h0, 0);
    step("pend80", 0, 0, 32'h0, 0, 0, 0, REDIR, 32'h80, 0);
    idle("post_pend", 0);

    step("yb1", 0, 1, 32'h100, 1, 0, 0, FRZ, 32'h0, 0);
    step("yb2", 0, 1, 32'h200, 1, 0, 0, FRZ, 32'h0, 0);
    step("pend200", 0, 0, 32'h0, 0, 0, 0, REDIR, 32'h200, 0);

    step("lu_br", 1, 1, 32'hC0, 0, 0, 0, REDIR, 32'hC0, 0);
    step("lu", 1, 0, 32'h0, 0, 0, 0, LU, 32'h0, 0);
    idle("post_lu", 0);

    step("md_start", 0, 0, 32'h0, 0, 1, 0, MDW, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      step("md_wait", 0, 0, 32'h0, 0, 0, 0, MDW, 32'h0, 0);
    step("md_done", 0, 0, 32'h0, 0, 0, 1, MDREL, 32'h0, 0);
    idle("post_md", 0);

    step("br_md", 0, 1, 32'h44, 0, 1, 0, REDIR, 32'h44, 0);
    idle("no_md", 0);

    step("to_start", 0, 0, 32'h0, 0, 1, 0, MDW, 32'h0, 0);
    for (int i = 0; i < 7; i++)
      step("to_wait", 0, 0, 32'h0, 0, 0, 0, MDW, 32'h0, 0);
    step("to_rel", 0, 0, 32'h0, 0, 0, 0, MDREL, 32'h0, 0);
    idle("to_flag", 1);
    idle("to_sticky", 1);

    step("r_start", 0, 0, 32'h0, 0, 1, 0, MDW, 32'h0, 1);
    step("r_br", 0, 1, 32'h300, 0, 0, 0, MDW, 32'h0, 1);
    rst_n = 1'b0;
    check_reset("mid_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle("drop_pend", 0);
    idle("after_rst", 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_seq.md
Name: pipe_ctrl_seq

Overview:
Central pipeline sequencer for the 5-stage RV32 core. It merges the hazard unit's stall/flush requests with data-memory wait and multi-cycle mul/div busy. From these it drives the PC write enable, redirect select, and per-stage write/bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It holds a small FSM, a pending-redirect latch, a mul/div timeout counter and saturating performance counters.

Parameters:
XLEN, 32, width of PC/branch target
MD_TIMEOUT, 64, max cycles in MD_WAIT before forced exit
CNT_W, 16, width of performance counters

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
load_use_stall  input  1  hazard unit stall (load-use)
branch_flush  input  1  hazard unit flush (taken branch/jump resolved in EX/MEM)
branch_target  input  XLEN  redirect address, valid with branch_flush
mem_busy  input  1  data memory not ready; MEM stage must hold
md_start  input  1  mul/div op entering EX this cycle
md_done  input  1  mul/div result ready
pc_we  output  1  PC register write enable
pc_redirect  output  1  PC mux selects redirect_pc
redirect_pc  output  XLEN  redirect address
if_id_we  output  1  IF/ID write enable
if_id_flush  output  1  IF/ID clear to NOP
id_ex_we  output  1  ID/EX write enable
id_ex_bubble  output  1  ID/EX load NOP
ex_mem_we  output  1  EX/MEM write enable
ex_mem_bubble  output  1  EX/MEM load NOP
mem_wb_we  output  1  MEM/WB write enable
md_timeout  output  1  sticky error: mul/div exceeded MD_TIMEOUT
stall_cnt  output  CNT_W  cycles with pc_we=0 (saturating)
flush_cnt  output  CNT_W  redirects applied (saturating)

Behaviour:
- Reset (rst_n=0, async): state=RUN; pending_valid=0; pending_pc=0; md_cnt=0; md_timeout=0; counters=0. While rst_n=0, all *_we=0, pc_redirect=0, if_id_flush=0, bubbles=0, redirect_pc=0.
- Control outputs are combinational from state, pending regs and inputs. Zero-latency: the effect lands on the same clk edge.
- Default (RUN, no events): all *_we=1; flush/bubble/redirect=0.
- Priority in RUN, highest first:
  - mem_busy: freeze. All *_we=0 and no bubbles. If branch_flush=1, latch pending_valid=1 and pending_pc=branch_target. Stay in RUN.
  - Redirect: if branch_flush=1 or pending_valid=1: pc_we=1, pc_redirect=1, redirect_pc=branch_target if branch_flush else pending_pc. Also assert if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1. Clear pending_valid. flush_cnt+1. Overrides load_use_stall and md_start (the killed op does not start).
  - md_start: pc_we=if_id_we=id_ex_we=0, ex_mem_bubble=1, mem_wb_we=1. Go to MD_WAIT with md_cnt=0.
  - load_use_stall: pc_we=if_id_we=0, id_ex_bubble=1; EX/MEM and MEM/WB advance.
- MD_WAIT state:
  - pc_we=if_id_we=id_ex_we=0, ex_mem_bubble=1, mem_wb_we=1.
  - md_cnt increments each cycle.
  - If md_done=1: release. ex_mem_we=1, ex_mem_bubble=0, id_ex_bubble=1, pc/if_id still held. Go to RUN.
  - If md_cnt==MD_TIMEOUT-1 without md_done: set md_timeout=1 (sticky until reset), release as for md_done, go to RUN.
  - mem_busy in MD_WAIT: all *_we=0. md_cnt still counts. md_done is ignored; the mul/div unit holds done until accepted.
  - branch_flush in MD_WAIT: latched into pending (cannot occur architecturally; latched for safety). Applied on the first RUN cycle.
- Pending latch: a second branch_flush while pending_valid=1 overwrites pending_pc (youngest wins).
- stall_cnt increments on every cycle with rst_n=1 and pc_we=0. Both counters saturate at all-ones with no wrap.
- Reset mid-MD_WAIT or with pending set: all state cleared immediately; the redirect is dropped.

Test Plan:
- Reset release, no inputs for 5 cycles -> all *_we=1, bubbles=0, stall_cnt=0, flush_cnt=0.
- branch_flush=1 with branch_target=0x0000_0040 for 1 cycle -> same cycle pc_redirect=1, redirect_pc=0x40, if_id_flush=id_ex_bubble=ex_mem_bubble=1; flush_cnt=1.
- mem_busy=1 for 3 cycles, branch_flush=1 (target 0x80) in 2nd busy cycle -> all *_we=0 for 3 cycles; first cycle after busy drops: pc_redirect=1, redirect_pc=0x80; stall_cnt=3.
- load_use_stall=1 and branch_flush=1 together -> redirect taken, pc_we=1, no stall; stall_cnt unchanged.
- md_start, md_done 4 cycles later -> pc_we=0 for 5 cycles, ex_mem_bubble=1 on cycles 1-4, release on cycle 5, back in RUN.
- md_start, md_done never, MD_TIMEOUT=8 -> md_timeout=1 after 8 MD_WAIT cycles, FSM back in RUN; flag stays 1 until rst_n=0 asserted mid-operation, after which it reads 0.
